bus_xfer_ctrl: RTL and testbench

- Reader/sequencer end of the shared tri-state register bus.
- Register-file entries each drive the bus via a per-register output enable and capture via a per-register load strobe. This block accepts a transfer request (source index, destination index).
- It sequences the strobes: enable the source, wait for the bus to settle, strobe the destination load, then signal completion.
- It also captures the transferred byte for the datapath, and guarantees at most one bus driver at any time.

---
 rtl/bus_xfer_ctrl_pkg.sv | 12 +
 rtl/bus_xfer_ctrl_onehot_dec.sv | 14 +
 rtl/bus_xfer_ctrl.sv | 132 +++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and default sizes for the register-bus transfer sequencer.
package bus_xfer_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } xfer_state_e;

  localparam int DEF_DW   = 8;
  localparam int DEF_NREG = 8;
endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) out[i] = en && (idx == IW'(i));
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequencer for the shared tri-state register bus: drive, settle, load, complete.
// Optional macro XFER_SETTLE_EN stretches DRIVE to SETTLE cycles.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter  int NREG   = DEF_NREG,
  parameter  int DW     = DEF_DW,
  parameter  int SETTLE = 2,
  localparam int IW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IW-1:0]   req_src,
  input  logic [IW-1:0]   req_dst,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] ld,
  input  logic [DW-1:0]   bus_in,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            err
);
  if (SETTLE < 1) begin : g_bad_settle
    $error("bus_xfer_ctrl: SETTLE must be at least 1");
  end

  xfer_state_e     state_q, state_d;
  logic [IW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic [NREG-1:0] oe_q, oe_d, ld_q, ld_d;
  logic            ready_q, ready_d, done_q, done_d, err_q, err_d;

`ifdef XFER_SETTLE_EN
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
`ifdef XFER_SETTLE_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: if (req_valid && ready_q) begin
        src_d = req_src;
        dst_d = req_dst;
`ifdef XFER_SETTLE_EN
        cnt_d = CW'(SETTLE - 1);
`endif
        // Self-transfer is meaningless on a single bus; reject without driving.
        if (req_src == req_dst) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
`ifdef XFER_SETTLE_EN
        if (cnt_q == '0) state_d = LATCH;
        else             cnt_d   = cnt_q - 1'b1;
`else
        state_d = LATCH;
`endif
      end
      LATCH: begin
        rd_d    = bus_in;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // Strobes are decoded from the next state and registered, so they are glitch-free
  // and oe/ld change on the same edge as the state.
  onehot_dec #(.N(NREG)) u_oe_dec (
    .idx (src_d),
    .en  ((state_d == DRIVE) || (state_d == LATCH)),
    .out (oe_d)
  );

  onehot_dec #(.N(NREG)) u_ld_dec (
    .idx (dst_d),
    .en  (state_d == LATCH),
    .out (ld_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rd_q    <= '0;
      oe_q    <= '0;
      ld_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef XFER_SETTLE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rd_q    <= rd_d;
      oe_q    <= oe_d;
      ld_q    <= ld_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef XFER_SETTLE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign oe        = oe_q;
  assign ld        = ld_q;
  assign rd_data   = rd_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed table, corner sequences, random vs model.
module tb_bus_xfer_ctrl;
`ifdef XFER_SETTLE_EN
  localparam int SETTLE_TB = 4;
  localparam int DRV       = SETTLE_TB;
`else
  localparam int SETTLE_TB = 2;
  localparam int DRV       = 1;
`endif
  localparam int NREG = 8;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_src, req_dst;
  logic [7:0]    oe, ld;
  logic [7:0]    bus_in;
  logic [7:0]    rd_data;
  logic          done, err;

  int checks = 0;
  int errors = 0;

  bus_xfer_ctrl #(.NREG(NREG), .DW(DW), .SETTLE(SETTLE_TB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .oe(oe), .ld(ld), .bus_in(bus_in),
    .rd_data(rd_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] bus;
    logic [7:0] exp_oe;
    logic [7:0] exp_ld;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  // One directed transfer, checked cycle by cycle against its table record.
  task automatic run_vec(input vec_t v);
    int len;
    len = v.exp_err ? 1 : DRV + 2;
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1; req_src = v.src; req_dst = v.dst; bus_in = v.bus;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("oe_seq",   oe,   (!v.exp_err && k <= DRV + 1) ? v.exp_oe : 8'h00);
      chk("ld_seq",   ld,   (!v.exp_err && k == DRV + 1) ? v.exp_ld : 8'h00);
      chk("done_seq", done, k == len);
      chk("err_seq",  err,  (k == len) && v.exp_err);
      chk("ready_busy", req_ready, 0);
      if (k == len) chk("rd_at_done", rd_data, v.exp_rd);
    end
    @(negedge clk);
    chk("ready_after", req_ready, 1);
    chk("done_after",  done, 0);
  endtask

  // Reference model: a transfer is a sequence of cycles numbered from acceptance.
  bit         m_busy;
  int         m_k;
  logic [2:0] m_src, m_dst;
  bit         m_rej;
  logic [7:0] m_rd;

  initial begin
    int acc[$];
    int guard;
    logic [7:0] rd_hold;

    vecs[0] = '{3'd2, 3'd5, 8'hA7, 8'h04, 8'h20, 8'hA7, 1'b0};
    vecs[1] = '{3'd3, 3'd3, 8'h11, 8'h00, 8'h00, 8'hA7, 1'b1};
    vecs[2] = '{3'd0, 3'd7, 8'h3C, 8'h01, 8'h80, 8'h3C, 1'b0};
    vecs[3] = '{3'd7, 3'd0, 8'h5A, 8'h80, 8'h01, 8'h5A, 1'b0};
    vecs[4] = '{3'd6, 3'd6, 8'hEE, 8'h00, 8'h00, 8'h5A, 1'b1};

    reset = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; bus_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", oe, 0); chk("rst_ld", ld, 0); chk("rst_rd", rd_data, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bus keeps moving after the transfer; captured byte must not follow it.
    rd_hold = rd_data;
    for (int i = 0; i < 4; i++) begin
      bus_in = 8'(i * 37 + 1);
      @(negedge clk);
      chk("rd_hold", rd_data, 8'h5A);
    end

    // Request held continuously: acceptances spaced by the full transfer length.
    req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd4;
    guard = 0;
    while (acc.size() < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      chk("b2b_onehot_oe", $countones(oe) <= 1, 1);
      chk("b2b_onehot_ld", $countones(ld) <= 1, 1);
      if (req_ready) begin
        acc.push_back(guard);
        req_src = (acc.size() % 2) ? 3'd4 : 3'd1;
        req_dst = (acc.size() % 2) ? 3'd1 : 3'd4;
      end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    chk("b2b_count", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], DRV + 3);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 50);
    chk("b2b_drain", req_ready, 1);

    // Reset while the load strobe is active.
    req_valid = 1'b1; req_src = 3'd2; req_dst = 3'd5; bus_in = 8'h99;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (DRV + 1) @(negedge clk);
    chk("latch_ld", ld, 8'h20);
    #2 reset = 1'b1;
    #1;
    chk("rstl_oe", oe, 0); chk("rstl_ld", ld, 0);
    chk("rstl_done", done, 0); chk("rstl_rd", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstl_nodone", done, 0);
      chk("rstl_ready", req_ready, 1);
    end

    // Randomized traffic against the cycle-numbered model.
    m_busy = 0; m_k = 0; m_rd = 8'h00; m_src = '0; m_dst = '0; m_rej = 0;
    for (int c = 0; c < 400; c++) begin
      int len;
      @(negedge clk);
      len = m_rej ? 1 : DRV + 2;
      chk("rnd_ready", req_ready, !m_busy);
      chk("rnd_oe",   oe,   (m_busy && !m_rej && m_k <= DRV + 1) ? (8'h01 << m_src) : 8'h00);
      chk("rnd_ld",   ld,   (m_busy && !m_rej && m_k == DRV + 1) ? (8'h01 << m_dst) : 8'h00);
      chk("rnd_done", done, m_busy && m_k == len);
      chk("rnd_err",  err,  m_busy && m_rej && m_k == len);
      chk("rnd_rd",   rd_data, m_rd);
      req_valid = ($urandom_range(0, 3) != 0);
      req_src   = 3'($urandom_range(0, 7));
      req_dst   = ($urandom_range(0, 4) == 0) ? req_src : 3'($urandom_range(0, 7));
      bus_in    = 8'($urandom);
      if (m_busy) begin
        if (!m_rej && m_k == DRV + 1) m_rd = bus_in;
        if (m_k == len) m_busy = 0;
        else            m_k++;
      end else if (req_valid) begin
        m_busy = 1; m_k = 1; m_src = req_src; m_dst = req_dst;
        m_rej = (req_src == req_dst);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
